// File: rtl/int_responder.sv
// int_responder: queues trig-edge/periodic interrupt events, presents them one at a time on interrupt, retires them on an ack store
// Ports: clk, reset (sync, active-high), trig (rising edge queues an event),
//   m_int_addr/m_int_byteen (bridge store; ack when it hits ACK_ADDR's word while asserting),
//   interrupt (level to HWInt[2]), pending (queued events, saturating), ack_cnt (valid acks, wraps),
//   spurious (sticky: ack-shaped store outside ASSERT), timeout (sticky: event dropped by timeout).
// Optional feature macro INT_TIMEOUT_EN: auto-drop an event left unacknowledged for TIMEOUT cycles.
`timescale 1ns/1ps
module int_responder #(
  parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
  parameter int PERIOD = 0,
  parameter int HOLDOFF = 2,
  parameter int PEND_W = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic              interrupt,
  output logic [PEND_W-1:0] pending,
  output logic [15:0]       ack_cnt,
  output logic              spurious,
  output logic              timeout
);
  localparam int PW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [PW-1:0] per_cnt;
  logic trig_q, trig_edge, tick, ack_hit, ack_ok, drop;
  logic [PEND_W+1:0] sum;
  logic [PEND_W-1:0] pending_nx;
  assign trig_edge = trig & ~trig_q;
  assign tick = (PERIOD > 0) && (per_cnt == PW'(PERIOD - 1));
  // Forcing the two byte-offset bits on both sides compares the word address only.
  assign ack_hit = (|m_int_byteen) && ((m_int_addr | 32'h3) == (ACK_ADDR | 32'h3));
  assign ack_ok = ack_hit && state == S_ASSERT;
  assign interrupt = state == S_ASSERT;
`ifdef INT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] asrt_cnt;
  logic to_flag;
  // An ack in the last allowed cycle takes priority over the drop.
  assign drop = state == S_ASSERT && !ack_ok && asrt_cnt == TW'(TIMEOUT - 1);
  assign timeout = to_flag;
  always_ff @(posedge clk) begin
    if (reset) begin
      asrt_cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      asrt_cnt <= state == S_ASSERT ? asrt_cnt + 1'b1 : '0;
      to_flag <= to_flag | drop;
    end
  end
`else
  assign drop = 1'b0;
  assign timeout = 1'b0;
`endif
  // Two spare bits let the sum go above the saturation point or below zero before clamping.
  assign sum = {2'b00, pending} + (PEND_W+2)'(trig_edge) + (PEND_W+2)'(tick) - (PEND_W+2)'(ack_ok | drop);
  assign pending_nx = sum[PEND_W+1] ? '0 : sum[PEND_W] ? '1 : sum[PEND_W-1:0];
  always_comb begin
    state_nx = state;
    hold_nx = hold_cnt;
    case (state)
      S_IDLE: state_nx = pending != '0 ? S_ASSERT : S_IDLE;
      S_ASSERT:
        if (ack_ok || drop) begin
          state_nx = HOLDOFF > 0 ? S_HOLD : S_IDLE;
          hold_nx = HW'(HOLDOFF - 1);
        end
      S_HOLD: begin
        state_nx = hold_cnt == '0 ? S_IDLE : S_HOLD;
        hold_nx = hold_cnt == '0 ? hold_cnt : hold_cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      hold_cnt <= '0;
      per_cnt <= '0;
      trig_q <= 1'b0;
      pending <= '0;
      ack_cnt <= '0;
      spurious <= 1'b0;
    end else begin
      state <= state_nx;
      hold_cnt <= hold_nx;
      per_cnt <= (PERIOD == 0 || tick) ? '0 : per_cnt + 1'b1;
      trig_q <= trig;
      pending <= pending_nx;
      ack_cnt <= ack_cnt + 16'(ack_ok);
      spurious <= spurious | (ack_hit && state != S_ASSERT);
    end
  end
endmodule

// File: tb/tb_int_responder.sv
// tb_int_responder: directed self-checking bench for int_responder (three instances with different parameters)
`timescale 1ns/1ps
module tb_int_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic ra, ta, ia, sa, toa;
  logic [31:0] addr_a;
  logic [3:0] be_a, pa;
  logic [15:0] ca;
  logic rb, tgb, ib, sb, tob;
  logic [1:0] pb;
  logic [15:0] cb;
  logic rc, tgc, ic, sc, toc;
  logic [3:0] pc;
  logic [15:0] cc;
  int low, hi, n;
  int_responder u_a (.clk(clk), .reset(ra), .trig(ta), .m_int_addr(addr_a), .m_int_byteen(be_a),
    .interrupt(ia), .pending(pa), .ack_cnt(ca), .spurious(sa), .timeout(toa));
  int_responder #(.PERIOD(8), .PEND_W(2)) u_b (.clk(clk), .reset(rb), .trig(tgb), .m_int_addr(32'h0),
    .m_int_byteen(4'h0), .interrupt(ib), .pending(pb), .ack_cnt(cb), .spurious(sb), .timeout(tob));
  int_responder #(.TIMEOUT(4)) u_c (.clk(clk), .reset(rc), .trig(tgc), .m_int_addr(32'h0),
    .m_int_byteen(4'h0), .interrupt(ic), .pending(pc), .ack_cnt(cc), .spurious(sc), .timeout(toc));
  task automatic cyc(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    ra = 1; rb = 1; rc = 1; ta = 0; tgb = 0; tgc = 0; addr_a = 32'h7F20; be_a = 0;
    cyc(2);
    ra = 0;
    chk("rst_int", ia, 0); chk("rst_pend", pa, 0); chk("rst_ack", ca, 0);
    chk("rst_spur", sa, 0); chk("rst_to", toa, 0);
    cyc(20);
    chk("idle_int", ia, 0); chk("idle_pend", pa, 0); chk("idle_ack", ca, 0);
    ta = 1; cyc; ta = 0;
    chk("edge_pend", pa, 1); chk("edge_int_lag", ia, 0);
    cyc;
    chk("int_rise", ia, 1);
    cyc(2);
    chk("int_held", ia, 1);
    be_a = 4'hF; cyc; be_a = 0;
    chk("ack1_int", ia, 0); chk("ack1_cnt", ca, 1); chk("ack1_pend", pa, 0); chk("ack1_spur", sa, 0);
    cyc(3);
    for (int i = 0; i < 3; i++) begin
      ta = 1; cyc; ta = 0; cyc;
    end
    chk("burst_pend", pa, 3); chk("burst_int", ia, 1);
    for (int i = 0; i < 3; i++) begin
      chk("burst_hi", ia, 1);
      be_a = 4'hF; cyc; be_a = 0;
      chk("burst_lo", ia, 0);
      if (i < 2) begin
        low = 0;
        while (!ia && low < 20) begin
          low++;
          cyc;
        end
        chk("burst_gap", low, 3);
      end
    end
    cyc(5);
    chk("burst_end_int", ia, 0); chk("burst_end_pend", pa, 0); chk("burst_end_cnt", ca, 4);
    ta = 1; cyc(10); ta = 0;
    chk("held_pend", pa, 1); chk("held_int", ia, 1);
    cyc;
    chk("held_pend2", pa, 1);
    be_a = 4'hF; cyc; be_a = 0;
    chk("held_ack_cnt", ca, 5); chk("held_ack_pend", pa, 0);
    cyc(3);
    chk("spur_pre", sa, 0);
    be_a = 4'hF; cyc; be_a = 0;
    chk("spur_set", sa, 1); chk("spur_pend", pa, 0); chk("spur_int", ia, 0); chk("spur_cnt", ca, 5);
    ta = 1; cyc; ta = 0; cyc;
    chk("wa_int", ia, 1);
    addr_a = 32'h7F24; be_a = 4'hF; cyc(2);
    chk("wa_int_hold", ia, 1); chk("wa_cnt", ca, 5); chk("wa_pend", pa, 1);
    addr_a = 32'h7F20; be_a = 0; cyc;
    chk("be0_int", ia, 1);
    addr_a = 32'h7F23; be_a = 4'b0001; cyc; be_a = 0;
    chk("byte_ack_cnt", ca, 6); chk("byte_ack_int", ia, 0); chk("byte_ack_pend", pa, 0);
    chk("a_to", toa, 0);
    cyc;
    rb = 0;
    cyc(7);
    chk("tick_early", pb, 0);
    tgb = 1; cyc; tgb = 0;
    chk("tick_plus_edge", pb, 2);
    cyc(8);
    chk("tick_sat", pb, 3);
    tgb = 1; cyc; tgb = 0;
    cyc(7);
    chk("sat_hold", pb, 3); chk("sat_int", ib, 1); chk("b_ack", cb, 0);
    rb = 1; cyc;
    chk("rst_mid_int", ib, 0); chk("rst_mid_pend", pb, 0);
    rb = 0; rc = 0;
    tgc = 1; cyc; tgc = 0;
    n = 0;
    while (!ic && n < 10) begin
      n++;
      cyc;
    end
    chk("c_rise", ic, 1);
    hi = 0;
    while (ic && hi < 20) begin
      hi++;
      cyc;
    end
`ifdef INT_TIMEOUT_EN
    chk("to_high", hi, 4); chk("to_flag", toc, 1); chk("to_pend", pc, 0);
`else
    chk("to_high", hi, 20); chk("to_flag", toc, 0); chk("to_pend", pc, 1);
`endif
    chk("to_cnt", cc, 0); chk("to_spur", sc, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
